// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types and helpers for the filter path
// Purpose: frame geometry constants, output mode encoding, RGB444 pixel
//          type and the 6-bit grayscale reduction used by the Sobel block.
// Ports:   none (package).
package filter_pkg;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_GRAY     = 2'd1,
    MODE_EDGE     = 2'd2,
    MODE_EDGE_INV = 2'd3
  } mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // R + 2G + B, range 0..60; green weighted double as the eye sees it most.
  function automatic logic [5:0] rgb2gray6(input rgb444_t p);
    return {2'b00, p.r} + {1'b0, p.g, 1'b0} + {2'b00, p.b};
  endfunction

endpackage

// File: rtl/sobel_grad.sv
// rtl/sobel_grad.sv - combinational Sobel gradient of a 3x3 gray window
// Purpose: computes horizontal and vertical Sobel gradients.
// Ports:   g00..g22 in  6-bit gray values, row 0 oldest, column 0 left
//          gx, gy   out signed 10-bit gradients, range +/-240
module sobel_grad (
  input  logic [5:0]        g00,
  input  logic [5:0]        g01,
  input  logic [5:0]        g02,
  input  logic [5:0]        g10,
  input  logic [5:0]        g11,
  input  logic [5:0]        g12,
  input  logic [5:0]        g20,
  input  logic [5:0]        g21,
  input  logic [5:0]        g22,
  output logic signed [9:0] gx,
  output logic signed [9:0] gy
);

  // a + 2b + c widened to 10 bits so the difference below cannot wrap.
  function automatic logic signed [9:0] tap3(input logic [5:0] a,
                                             input logic [5:0] b,
                                             input logic [5:0] c);
    return $signed({4'b0000, a} + {3'b000, b, 1'b0} + {4'b0000, c});
  endfunction

  // The centre pixel has zero weight in both kernels.
  logic [5:0] unused_centre;
  assign unused_centre = g11;

  assign gx = tap3(g02, g12, g22) - tap3(g00, g10, g20);
  assign gy = tap3(g20, g21, g22) - tap3(g00, g01, g02);

endmodule

// File: rtl/sobel_window_filter.sv
// rtl/sobel_window_filter.sv - 3-stage Sobel/gray/passthrough window filter
// Purpose: reduces each registered 3x3 RGB444 window to one output pixel,
//          keeps x/y/de raster-aligned (3 cycle latency) and counts edge
//          pixels per complete frame.
// Ports:   clk, reset (sync, active-high)
//          win_de/win_x/win_y, p00..p22   input window and centre coordinate
//          mode, threshold                 filter select and edge level
//          out_de/out_x/out_y/out_pixel    filtered stream
//          edge_count, edge_count_valid    per-frame edge total and pulse
module sobel_window_filter #(
  parameter int H_ACT = filter_pkg::H_ACT,
  parameter int V_ACT = filter_pkg::V_ACT,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             win_de,
  input  logic [9:0]       win_x,
  input  logic [9:0]       win_y,
  input  logic [11:0]      p00,
  input  logic [11:0]      p01,
  input  logic [11:0]      p02,
  input  logic [11:0]      p10,
  input  logic [11:0]      p11,
  input  logic [11:0]      p12,
  input  logic [11:0]      p20,
  input  logic [11:0]      p21,
  input  logic [11:0]      p22,
  input  logic [1:0]       mode,
  input  logic [8:0]       threshold,
  output logic             out_de,
  output logic [9:0]       out_x,
  output logic [9:0]       out_y,
  output logic [11:0]      out_pixel,
  output logic [CNT_W-1:0] edge_count,
  output logic             edge_count_valid
);
  import filter_pkg::*;

  localparam logic [9:0] X_LAST = 10'(H_ACT - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACT - 1);

  // Stage 1: gray conversion; index 0 = p00 ... index 8 = p22.
  logic            s1_de;
  logic [9:0]      s1_x, s1_y;
  logic [8:0][5:0] s1_g;
  rgb444_t         s1_c;
  mode_e           s1_mode;
  logic [8:0]      s1_thr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de   <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_g    <= '0;
      s1_c    <= '0;
      s1_mode <= MODE_PASS;
      s1_thr  <= '0;
    end else begin
      s1_de   <= win_de;
      s1_x    <= win_x;
      s1_y    <= win_y;
      s1_g    <= {rgb2gray6(p22), rgb2gray6(p21), rgb2gray6(p20),
                  rgb2gray6(p12), rgb2gray6(p11), rgb2gray6(p10),
                  rgb2gray6(p02), rgb2gray6(p01), rgb2gray6(p00)};
      s1_c    <= p11;
      s1_mode <= mode_e'(mode);
      s1_thr  <= threshold;
    end
  end

  // Stage 2: gradients.
  logic signed [9:0] gx_w, gy_w;

  sobel_grad u_grad (
    .g00(s1_g[0]), .g01(s1_g[1]), .g02(s1_g[2]),
    .g10(s1_g[3]), .g11(s1_g[4]), .g12(s1_g[5]),
    .g20(s1_g[6]), .g21(s1_g[7]), .g22(s1_g[8]),
    .gx (gx_w),
    .gy (gy_w)
  );

  logic              s2_de;
  logic [9:0]        s2_x, s2_y;
  logic signed [9:0] s2_gx, s2_gy;
  rgb444_t           s2_c;
  logic [5:0]        s2_gc;
  mode_e             s2_mode;
  logic [8:0]        s2_thr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_de   <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
      s2_gx   <= '0;
      s2_gy   <= '0;
      s2_c    <= '0;
      s2_gc   <= '0;
      s2_mode <= MODE_PASS;
      s2_thr  <= '0;
    end else begin
      s2_de   <= s1_de;
      s2_x    <= s1_x;
      s2_y    <= s1_y;
      s2_gx   <= gx_w;
      s2_gy   <= gy_w;
      s2_c    <= s1_c;
      s2_gc   <= s1_g[4];
      s2_mode <= s1_mode;
      s2_thr  <= s1_thr;
    end
  end

  // Stage 3: magnitude, edge decision and output mux.
  logic [9:0]  abs_x, abs_y, mag;
  logic        edge_w;
  logic [11:0] pix_w;

  assign abs_x  = s2_gx[9] ? 10'(-s2_gx) : 10'(s2_gx);
  assign abs_y  = s2_gy[9] ? 10'(-s2_gy) : 10'(s2_gy);
  assign mag    = abs_x + abs_y;
  assign edge_w = mag > {1'b0, s2_thr};

  always_comb begin
    pix_w = 12'h000;
    case (s2_mode)
      MODE_PASS:     pix_w = s2_c;
      MODE_GRAY:     pix_w = {s2_gc[5:2], s2_gc[5:2], s2_gc[5:2]};
      MODE_EDGE:     pix_w = edge_w ? 12'hFFF : 12'h000;
      MODE_EDGE_INV: pix_w = edge_w ? 12'h000 : 12'hFFF;
      default:       pix_w = 12'h000;
    endcase
  end

  logic first_px, last_px;
  assign first_px = (s2_x == 10'd0) && (s2_y == 10'd0);
  assign last_px  = (s2_x == X_LAST) && (s2_y == Y_LAST);

  logic [CNT_W-1:0] acc;
  logic             frame_started;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_de           <= 1'b0;
      out_x            <= '0;
      out_y            <= '0;
      out_pixel        <= '0;
      acc              <= '0;
      frame_started    <= 1'b0;
      edge_count       <= '0;
      edge_count_valid <= 1'b0;
    end else begin
      out_de           <= s2_de;
      out_x            <= s2_x;
      out_y            <= s2_y;
      out_pixel        <= s2_de ? pix_w : 12'h000;
      edge_count_valid <= 1'b0;
      if (s2_de) begin
        if (first_px) begin
          acc           <= CNT_W'(edge_w);
          frame_started <= 1'b1;
        end else begin
          acc <= acc + CNT_W'(edge_w);
        end
        // A frame entered mid-way (after reset) never publishes a count.
        if (last_px && frame_started) begin
          edge_count       <= acc + CNT_W'(edge_w);
          edge_count_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_filter.sv
// tb/tb_sobel_window_filter.sv - self-checking bench for sobel_window_filter
module tb_sobel_window_filter;

  localparam int H  = 16;
  localparam int V  = 12;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          win_de;
  logic [9:0]    win_x, win_y;
  logic [11:0]   w [9];
  logic [1:0]    mode;
  logic [8:0]    threshold;
  logic          out_de;
  logic [9:0]    out_x, out_y;
  logic [11:0]   out_pixel;
  logic [CW-1:0] edge_count;
  logic          edge_count_valid;

  always #5 clk = ~clk;

  sobel_window_filter #(.H_ACT(H), .V_ACT(V), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .win_de(win_de), .win_x(win_x), .win_y(win_y),
    .p00(w[0]), .p01(w[1]), .p02(w[2]),
    .p10(w[3]), .p11(w[4]), .p12(w[5]),
    .p20(w[6]), .p21(w[7]), .p22(w[8]),
    .mode(mode), .threshold(threshold),
    .out_de(out_de), .out_x(out_x), .out_y(out_y), .out_pixel(out_pixel),
    .edge_count(edge_count), .edge_count_valid(edge_count_valid)
  );

  typedef struct {
    logic          de;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [11:0]   pix;
    logic          v;
    logic [CW-1:0] cnt;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_m = 0;
  int   cnt_m = 0;
  bit   started_m = 0;
  int   pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gray(input logic [11:0] p);
    return int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0]);
  endfunction

  function automatic int edge_of(input int thr);
    int g [9];
    int gx, gy, mag;
    for (int i = 0; i < 9; i++) g[i] = gray(w[i]);
    gx  = (g[2] + 2 * g[5] + g[8]) - (g[0] + 2 * g[3] + g[6]);
    gy  = (g[6] + 2 * g[7] + g[8]) - (g[0] + 2 * g[1] + g[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > thr) ? 1 : 0;
  endfunction

  function automatic rec_t zero_rec();
    rec_t r;
    r.de = 0; r.x = 0; r.y = 0; r.pix = 0; r.v = 0; r.cnt = 0;
    return r;
  endfunction

  // Drive one window for one cycle; compare the output of three cycles ago.
  task automatic apply(input logic de, input int x, input int y,
                       input int md, input int thr, input int kpix);
    rec_t r;
    int e;
    logic [3:0] g4;
    win_de = de; win_x = 10'(x); win_y = 10'(y);
    mode = 2'(md); threshold = 9'(thr);
    e  = edge_of(thr);
    g4 = 4'(gray(w[4]) / 4);
    r.de = de; r.x = win_x; r.y = win_y; r.v = 0;
    if (!de)           r.pix = 12'h000;
    else if (kpix >= 0) r.pix = 12'(kpix);
    else case (md)
      0:       r.pix = w[4];
      1:       r.pix = {g4, g4, g4};
      2:       r.pix = e ? 12'hFFF : 12'h000;
      default: r.pix = e ? 12'h000 : 12'hFFF;
    endcase
    if (de) begin
      if (x == 0 && y == 0) begin
        acc_m = e; started_m = 1;
      end else begin
        acc_m += e;
      end
      if (x == H - 1 && y == V - 1 && started_m) begin
        cnt_m = acc_m; r.v = 1;
      end
    end
    r.cnt = CW'(cnt_m);
    q.push_back(r);
    @(posedge clk); #1;
    if (edge_count_valid === 1'b1) pulses++;
    if (q.size() >= 3) begin
      r = q.pop_front();
      check("out_de", 32'(out_de), 32'(r.de));
      check("out_x", 32'(out_x), 32'(r.x));
      check("out_y", 32'(out_y), 32'(r.y));
      check("out_pixel", 32'(out_pixel), 32'(r.pix));
      check("edge_count_valid", 32'(edge_count_valid), 32'(r.v));
      check("edge_count", 32'(edge_count), 32'(r.cnt));
    end
  endtask

  task automatic rand_win();
    for (int i = 0; i < 9; i++) w[i] = 12'($urandom);
  endtask

  task automatic uni(input logic [11:0] p);
    for (int i = 0; i < 9; i++) w[i] = p;
  endtask

  task automatic step_win();
    for (int i = 0; i < 9; i++) w[i] = (i % 3 == 0) ? 12'h000 : 12'hFFF;
  endtask

  task automatic drain(input int thr);
    repeat (3) apply(1'b0, 1, 1, 0, thr, -1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      rand_win();
      win_de = 1'b1; win_x = 10'($urandom); win_y = 10'($urandom);
      @(posedge clk); #1;
      check("rst_out_de", 32'(out_de), 0);
      check("rst_out_x", 32'(out_x), 0);
      check("rst_out_y", 32'(out_y), 0);
      check("rst_out_pixel", 32'(out_pixel), 0);
      check("rst_edge_count", 32'(edge_count), 0);
      check("rst_edge_count_valid", 32'(edge_count_valid), 0);
    end
    reset = 1'b0;
    q.delete();
    q.push_back(zero_rec());
    q.push_back(zero_rec());
    acc_m = 0; cnt_m = 0; started_m = 0;
  endtask

  // Feed rows y0..y1 with random bubbles; optional uniform (edge-free)
  // windows and a forced edge on the frame's final pixel.
  task automatic feed(input int y0, input int y1, input int thr,
                      input bit uniform, input bit last_edge);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < H; x++) begin
        if ($urandom_range(0, 3) == 0) begin
          rand_win();
          apply(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 3), thr, -1);
        end
        if (uniform) uni(12'($urandom));
        else         rand_win();
        if (last_edge && x == H - 1 && y == V - 1) step_win();
        apply(1'b1, x, y, $urandom_range(0, 3), thr, -1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; win_de = 1'b0; win_x = '0; win_y = '0;
    mode = '0; threshold = '0;
    uni(12'h000);
    do_reset(3);

    // Directed windows with fixed expected pixels.
    uni(12'h888); apply(1'b1, 5, 3, 2, 0, 12'h000);   drain(0);
    step_win();   apply(1'b1, 6, 3, 2, 100, 12'hFFF); drain(100);
    step_win();   apply(1'b1, 7, 3, 2, 240, 12'h000); drain(240);
    uni(12'hF0F); apply(1'b1, 8, 3, 1, 240, 12'h777); drain(240);
    uni(12'hF0F); apply(1'b1, 9, 3, 0, 240, 12'hF0F); drain(240);
    step_win();   apply(1'b1, 2, 4, 3, 100, 12'h000); drain(100);

    // Full frame with a forced last-pixel edge, then an edge-free frame
    // back-to-back at the same threshold.
    pulses = 0;
    feed(0, V - 1, 150, 1'b0, 1'b1);
    feed(0, V - 1, 150, 1'b1, 1'b0);
    drain(150);
    check("pulses_two_frames", 32'(pulses), 2);
    check("zero_edge_frame_count", 32'(edge_count), 0);

    // Reset mid-frame, resume after the reset row: no pulse.
    feed(0, 5, 200, 1'b0, 1'b0);
    do_reset(2);
    pulses = 0;
    feed(7, V - 1, 200, 1'b0, 1'b1);
    drain(200);
    check("no_pulse_after_reset", 32'(pulses), 0);

    // Next complete frame is counted again.
    feed(0, V - 1, 200, 1'b0, 1'b1);
    drain(200);
    check("pulse_after_full_frame", 32'(pulses), 1);
    check("final_edge_count", 32'(edge_count), 32'(cnt_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_filter.md
Name: sobel_window_filter

Overview:
- Consumes the registered 3x3 RGB444 neighbourhood produced by the filter-path line buffer, together with the raster coordinates for that window.
- Reduces each window to one output pixel: centre passthrough, grayscale, or binary Sobel edge.
- Re-times `x`/`y`/`de` so the output stream stays raster-aligned for the VGA output path and motion-detect logic.
- Also counts edge pixels per frame so the game logic can detect motion.

Parameters:
- H_ACT, 640, active pixels per line; last column is H_ACT-1.
- V_ACT, 480, active lines per frame; last row is V_ACT-1.
- CNT_W, 19, edge-counter width; must hold H_ACT*V_ACT.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- win_de  in  1  window valid; the 9 pixels and coordinates below are meaningful.
- win_x  in  10  column of the centre pixel.
- win_y  in  10  row of the centre pixel.
- p00..p22  in  12 each  window pixels {R[11:8],G[7:4],B[3:0]}; row 0 is the oldest line; column 0 is the left neighbour.
- mode  in  2  0=centre passthrough, 1=grayscale, 2=edge, 3=edge inverted.
- threshold  in  9  edge decision level for |Gx|+|Gy|.
- out_de  out  1  output pixel valid.
- out_x  out  10  output column.
- out_y  out  10  output row.
- out_pixel  out  12  filtered RGB444.
- edge_count  out  CNT_W  edge pixels in last complete frame.
- edge_count_valid  out  1  one-cycle pulse when edge_count updates.

Behaviour:
- Reset: every output and every pipeline register is 0; the frame accumulator is 0.
- Latency: fixed 3 cycles, win_* at cycle N gives out_* at N+3. win_de=0 bubbles propagate with out_de=0.
  - out_x/out_y are always the win_x/win_y delayed 3 cycles.
  - out_pixel=0 whenever out_de=0.
- Stage 1 (gray):
  - Per pixel, g = R + 2G + B, unsigned 6 bits, range 0..60.
  - The centre RGB and mode are registered alongside, so mode is sampled at input, not at output.
- Stage 2 (gradient):
  - Gx = (g02+2g12+g22) - (g00+2g10+g20).
  - Gy = (g20+2g21+g22) - (g00+2g01+g02).
  - Both are signed 10 bits, range ±240.
- Stage 3 (output):
  - mag = |Gx|+|Gy|, unsigned 9 bits, max 480, no saturation needed.
  - edge = mag > threshold (strict).
  - mode 0: out_pixel = centre.
  - mode 1: out_pixel = {g[5:2],g[5:2],g[5:2]} of the centre.
  - mode 2: out_pixel = edge ? 12'hFFF : 12'h000.
  - mode 3: out_pixel = the complement of the mode 2 value.
- Borders: the line buffer already zeroes out-of-frame neighbours. This block performs no extra masking; zero neighbours are treated as black.
- Edge counter:
  - The counter operates on stage-3 signals and is independent of mode.
  - On out_de with (x,y)=(0,0), the accumulator loads edge (0 or 1).
  - On other out_de cycles, the accumulator adds edge.
  - On out_de with (x,y)=(H_ACT-1,V_ACT-1), edge_count is loaded with the final total including that pixel, and edge_count_valid pulses the same cycle.
  - edge_count holds until the next frame end.
- Reset mid-frame: the pipeline is flushed. No edge_count_valid pulse occurs until a frame has been seen from (0,0) through the last pixel.
  - Tracked by a frame_started flag, set at (0,0), cleared by reset.
  - If the last pixel arrives without frame_started, there is no update and no pulse.
- Back-to-back frames: (0,0) directly after the last pixel is legal. Latch and restart are independent registers.
- Coordinates are never range-checked except for the two compares above.

Decomposition:
- Shared package filter_pkg:
  - H_ACT/V_ACT constants.
  - MODE_PASS/MODE_GRAY/MODE_EDGE/MODE_EDGE_INV enum (2 bits).
  - rgb444_t typedef.
  - Function rgb2gray6().
- One natural sub-module: sobel_grad (pure stage-2 arithmetic, 9 gray inputs → signed Gx/Gy), instantiated once.
- Counter logic stays in the top.

Test Plan:
- Uniform window, all p=12'h888, mode=2, threshold=0: g=32, Gx=Gy=0 → out_pixel=000 at N+3, out_x/out_y equal the inputs from N.
- Vertical step, left column 000, centre/right columns FFF, mode=2, threshold=100: g=60, Gx=240, Gy=0 → FFF. The same stimulus with threshold=240 → 000 (strict compare).
- mode=1 with centre 12'hF0F: g=30 → out_pixel=12'h777. mode=0 with the same input → 12'hF0F. mode=3 with the step window → 000.
- Full 640x480 frame, edge true exactly at 1000 pixels including the last pixel → edge_count=1000 with a single edge_count_valid pulse at out (639,479). A second frame with 0 edges → edge_count=0.
- Assert reset at row 200, then release; feed from row 201 to frame end → no pulse. The next full frame gives the correct count. All outputs are 0 during reset.
- Random win_de gaps (bubbles) throughout → out_de matches the input de delayed 3 cycles. out_pixel=0 and the counter is unchanged on gap cycles.
